signed_bcd_formatter: RTL and testbench

- Parametrised, handshaked successor to the output unit's sign/blanking stage.
- Accepts an N-digit BCD magnitude plus sign bit and scans it MSD→LSD, one digit per cycle.
- Emits a registered, display-ready code vector with:
  - leading-zero blanking,
  - a minus placed immediately left of the most significant nonzero digit,
  - suppression of negative zero,
  - overflow and bad-digit error display.
- Sits between the binary-to-BCD converter and the seven-segment decoder/scanner.

---
 rtl/display_codes_pkg.sv | 17 +
 rtl/bcd_digit_classify.sv | 14 +
 rtl/signed_bcd_formatter.sv | 159 +++++++++++++++
 tb/tb_signed_bcd_formatter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_codes_pkg.sv
// Display code constants, digit code type and formatter FSM states
// shared by the signed BCD formatter and its helpers.
package display_codes_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t CODE_MINUS = 4'hE;
  localparam digit_t CODE_BLANK = 4'hF;
  localparam digit_t CODE_ERR   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_HOLD
  } state_t;

endpackage

// File: rtl/bcd_digit_classify.sv
// Combinational classifier for one BCD nibble:
// flags zero and non-decimal (>9) values.
module bcd_digit_classify
  import display_codes_pkg::*;
(
  input  digit_t i_nibble,
  output logic   o_is_zero,
  output logic   o_is_bad
);

  assign o_is_zero = (i_nibble == 4'd0);
  assign o_is_bad  = (i_nibble > 4'd9);

endmodule

// File: rtl/signed_bcd_formatter.sv
// Sign placement and leading-zero blanking for an N-digit BCD value,
// scanned MSD to LSD one digit per cycle with valid/ready handshakes.
module signed_bcd_formatter
  import display_codes_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit BLANK_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_codes,
  output logic                  out_overflow,
  output logic                  out_bad_digit
);

  localparam int IW = $clog2(DIGITS);

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic                r_sign;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] r_work;
  logic                r_found;
  logic                r_ovf;
  logic                r_bad;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [4*DIGITS-1:0] r_codes;
  logic                r_out_ovf;
  logic                r_out_bad;

  digit_t              w_digit;
  logic                w_is_zero;
  logic                w_is_bad;
  logic                w_first;
  logic                w_at_msd;
  logic [4*DIGITS-1:0] w_work;
  logic [4*DIGITS-1:0] w_err;
  logic                w_ovf;
  logic                w_bad;

  // Select the digit currently under the scan index.
  always_comb begin
    w_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == r_idx) w_digit = r_bcd[4*k +: 4];
    end
  end

  bcd_digit_classify u_classify (
    .i_nibble  (w_digit),
    .o_is_zero (w_is_zero),
    .o_is_bad  (w_is_bad)
  );

  assign w_first  = !r_found && !w_is_zero;
  assign w_at_msd = (r_idx == IW'(DIGITS-1));
  assign w_ovf    = r_ovf | (w_first & r_sign & w_at_msd);
  assign w_bad    = r_bad | w_is_bad;

  // Next work vector: write the scanned digit or blank, and drop a
  // minus one position left of the first nonzero digit.
  always_comb begin
    w_work = r_work;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == r_idx) begin
        if (!r_found && w_is_zero && k != 0)
          w_work[4*k +: 4] = BLANK_EN ? CODE_BLANK : 4'h0;
        else
          w_work[4*k +: 4] = w_digit;
      end
    end
    for (int j = 1; j < DIGITS; j++) begin
      if (w_first && r_sign && IW'(j-1) == r_idx)
        w_work[4*j +: 4] = CODE_MINUS;
    end
  end

  // Error display: blanks everywhere except an error mark in digit 0.
  always_comb begin
    w_err = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_err[4*k +: 4] = (k == 0) ? CODE_ERR : CODE_BLANK;
    end
  end

  // Control FSM with registered handshakes and latched results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= IW'(DIGITS-1);
      r_sign      <= 1'b0;
      r_bcd       <= '0;
      r_work      <= {DIGITS{CODE_BLANK}};
      r_found     <= 1'b0;
      r_ovf       <= 1'b0;
      r_bad       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_codes     <= {DIGITS{CODE_BLANK}};
      r_out_ovf   <= 1'b0;
      r_out_bad   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_sign     <= in_sign;
            r_bcd      <= in_bcd;
            r_work     <= {DIGITS{CODE_BLANK}};
            r_found    <= 1'b0;
            r_ovf      <= 1'b0;
            r_bad      <= 1'b0;
            r_idx      <= IW'(DIGITS-1);
            r_in_ready <= 1'b0;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_work  <= w_work;
          r_found <= r_found | w_first;
          r_ovf   <= w_ovf;
          r_bad   <= w_bad;
          if (r_idx == '0) begin
            r_codes     <= (w_ovf || w_bad) ? w_err : w_work;
            r_out_ovf   <= w_ovf;
            r_out_bad   <= w_bad;
            r_out_valid <= 1'b1;
            r_idx       <= IW'(DIGITS-1);
            r_state     <= S_HOLD;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_codes     = r_codes;
  assign out_overflow  = r_out_ovf;
  assign out_bad_digit = r_out_bad;

endmodule

// File: tb/tb_signed_bcd_formatter.sv
// Randomized and directed checks of signed_bcd_formatter against a
// behavioural display model; index 1 blanks zeros, index 0 does not.
module tb_signed_bcd_formatter;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_ready, in_sign;
  logic [1:0]  out_valid, out_ready, ovf, bad;
  logic [15:0] in_bcd [2];
  logic [15:0] codes [2];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  signed_bcd_formatter #(.DIGITS(D), .BLANK_EN(1'b1)) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid[1]),
    .in_ready      (in_ready[1]),
    .in_sign       (in_sign[1]),
    .in_bcd        (in_bcd[1]),
    .out_valid     (out_valid[1]),
    .out_ready     (out_ready[1]),
    .out_codes     (codes[1]),
    .out_overflow  (ovf[1]),
    .out_bad_digit (bad[1])
  );

  signed_bcd_formatter #(.DIGITS(D), .BLANK_EN(1'b0)) u_dut0 (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid[0]),
    .in_ready      (in_ready[0]),
    .in_sign       (in_sign[0]),
    .in_bcd        (in_bcd[0]),
    .out_valid     (out_valid[0]),
    .out_ready     (out_ready[0]),
    .out_codes     (codes[0]),
    .out_overflow  (ovf[0]),
    .out_bad_digit (bad[0])
  );

  // Display model: find the top nonzero nibble, blank/zero above it,
  // minus just left of it, error pattern on overflow or bad nibble.
  function automatic void model(input bit sg, input logic [15:0] b,
                                input bit blank, output logic [15:0] c,
                                output bit ov, output bit bd);
    int m = -1;
    bd = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (b[4*k +: 4] > 4'd9) bd = 1'b1;
      if (b[4*k +: 4] != 4'd0) m = k;
    end
    ov = sg && (m == D-1);
    for (int k = 0; k < D; k++) begin
      if (k > m) c[4*k +: 4] = (k == 0) ? 4'h0 : (blank ? 4'hF : 4'h0);
      else       c[4*k +: 4] = b[4*k +: 4];
    end
    if (sg && m >= 0 && m < D-1) c[4*(m+1) +: 4] = 4'hE;
    if (bd || ov) c = 16'hFFFB;
  endfunction

  function automatic logic [15:0] gen_bcd();
    logic [15:0] b;
    int lz = $urandom_range(0, D);
    for (int k = 0; k < D; k++) begin
      if ($urandom_range(0, 19) == 0) b[4*k +: 4] = 4'($urandom_range(10, 15));
      else                           b[4*k +: 4] = 4'($urandom_range(0, 9));
      if (k >= D - lz) b[4*k +: 4] = 4'h0;
    end
    return b;
  endfunction

  // Offer one value; returns at the negedge after the accept edge.
  task automatic send(input int s, input bit sg, input logic [15:0] b,
                      output int acc);
    int n = 0;
    @(negedge clk);
    while (!in_ready[s] && n < 40) begin @(negedge clk); n++; end
    nchk++;
    if (!in_ready[s]) begin
      nerr++;
      $display("FAIL send_wait dut%0d in_ready=%0b want 1", s, in_ready[s]);
    end
    acc = cyc;
    in_valid[s] = 1'b1; in_sign[s] = sg; in_bcd[s] = b;
    @(negedge clk);
    in_valid[s] = 1'b0; in_sign[s] = ~sg; in_bcd[s] = 16'($urandom);
  endtask

  task automatic wait_out(input int s, output int lat);
    lat = 0;
    while (!out_valid[s] && lat < 40) begin @(negedge clk); lat++; end
    nchk++;
    if (!out_valid[s]) begin
      nerr++;
      $display("FAIL wait_out dut%0d out_valid=0 want 1", s);
    end
  endtask

  task automatic ack(input int s);
    out_ready[s] = 1'b1;
    @(negedge clk);
    out_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    for (int s = 0; s < 2; s++) begin
      nchk++;
      if (in_ready[s] !== 1'b0 || out_valid[s] !== 1'b0 ||
          codes[s] !== 16'hFFFF || ovf[s] !== 1'b0 || bad[s] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_state dut%0d rdy=%b vld=%b codes=%h ovf=%b bad=%b want 0 0 ffff 0 0",
                 s, in_ready[s], out_valid[s], codes[s], ovf[s], bad[s]);
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      nchk++;
      if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_release dut%0d in_ready=%b out_valid=%b want 1 0",
                 s, in_ready[s], out_valid[s]);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] vb [6] = '{16'h0042, 16'h0000, 16'h0000,
                            16'h1234, 16'h1234, 16'h0A05};
    bit          vs [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] vc [6] = '{16'hFE42, 16'hFFF0, 16'hFFF0,
                            16'hFFFB, 16'h1234, 16'hFFFB};
    bit          vo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit          vd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int acc, lat;
    for (int i = 0; i < 6; i++) begin
      send(1, vs[i], vb[i], acc);
      wait_out(1, lat);
      nchk++;
      if (codes[1] !== vc[i] || ovf[1] !== vo[i] || bad[1] !== vd[i]) begin
        nerr++;
        $display("FAIL directed_%0d got codes=%h ovf=%b bad=%b want %h %b %b",
                 i, codes[1], ovf[1], bad[1], vc[i], vo[i], vd[i]);
      end
      nchk++;
      if (lat !== D) begin
        nerr++;
        $display("FAIL latency_%0d got %0d edges want %0d", i, lat, D);
      end
      ack(1);
    end
    send(0, 1'b1, 16'h0007, acc);
    wait_out(0, lat);
    nchk++;
    if (codes[0] !== 16'h00E7 || ovf[0] !== 1'b0 || bad[0] !== 1'b0) begin
      nerr++;
      $display("FAIL noblank_minus got codes=%h ovf=%b bad=%b want 00e7 0 0",
               codes[0], ovf[0], bad[0]);
    end
    ack(0);
  endtask

  task automatic test_random();
    logic [15:0] b, ec;
    bit sg, eo, ed;
    int acc, lat;
    for (int i = 0; i < 40; i++) begin
      int s = i % 2;
      b  = gen_bcd();
      sg = 1'($urandom);
      model(sg, b, s == 1, ec, eo, ed);
      send(s, sg, b, acc);
      wait_out(s, lat);
      nchk++;
      if (codes[s] !== ec || ovf[s] !== eo || bad[s] !== ed) begin
        nerr++;
        $display("FAIL random_%0d dut%0d in=%b/%h got %h %b %b want %h %b %b",
                 i, s, sg, b, codes[s], ovf[s], bad[s], ec, eo, ed);
      end
      ack(s);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    int acc, lat;
    send(1, 1'b1, 16'h0305, acc);
    wait_out(1, lat);
    c0 = codes[1];
    nchk++;
    if (c0 !== 16'hE305) begin
      nerr++;
      $display("FAIL bp_value got %h want e305", c0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nchk++;
      if (out_valid[1] !== 1'b1 || codes[1] !== c0 || in_ready[1] !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold_%0d vld=%b codes=%h rdy=%b want 1 %h 0",
                 i, out_valid[1], codes[1], in_ready[1], c0);
      end
    end
    out_ready[1] = 1'b1;
    #1;
    nchk++;
    if (in_ready[1] !== 1'b0) begin
      nerr++;
      $display("FAIL bp_same_cycle in_ready=%b want 0", in_ready[1]);
    end
    @(negedge clk);
    out_ready[1] = 1'b0;
    nchk++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || codes[1] !== c0) begin
      nerr++;
      $display("FAIL bp_release rdy=%b vld=%b codes=%h want 1 0 %h",
               in_ready[1], out_valid[1], codes[1], c0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b, ec;
    bit sg, eo, ed;
    int acc, prev, lat;
    out_ready[1] = 1'b1;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      b  = gen_bcd();
      sg = 1'($urandom);
      model(sg, b, 1'b1, ec, eo, ed);
      send(1, sg, b, acc);
      if (prev >= 0) begin
        nchk++;
        if (acc - prev !== D + 2) begin
          nerr++;
          $display("FAIL b2b_period_%0d got %0d cycles want %0d",
                   i, acc - prev, D + 2);
        end
      end
      prev = acc;
      wait_out(1, lat);
      nchk++;
      if (codes[1] !== ec || ovf[1] !== eo || bad[1] !== ed) begin
        nerr++;
        $display("FAIL b2b_%0d in=%b/%h got %h %b %b want %h %b %b",
                 i, sg, b, codes[1], ovf[1], bad[1], ec, eo, ed);
      end
    end
    @(negedge clk);
    out_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic [15:0] ec;
    bit eo, ed;
    int acc, lat;
    send(1, 1'b0, 16'h1234, acc);
    wait_out(1, lat);
    ack(1);
    send(1, 1'b1, 16'h0042, acc);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    nchk++;
    if (out_valid[1] !== 1'b0 || codes[1] !== 16'hFFFF ||
        in_ready[1] !== 1'b0 || ovf[1] !== 1'b0 || bad[1] !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset vld=%b codes=%h rdy=%b ovf=%b bad=%b want 0 ffff 0 0 0",
               out_valid[1], codes[1], in_ready[1], ovf[1], bad[1]);
    end
    @(negedge clk);
    reset = 1'b0;
    model(1'b1, 16'h0908, 1'b1, ec, eo, ed);
    send(1, 1'b1, 16'h0908, acc);
    wait_out(1, lat);
    nchk++;
    if (codes[1] !== ec || ovf[1] !== eo || bad[1] !== ed || lat !== D) begin
      nerr++;
      $display("FAIL after_reset got %h %b %b lat=%0d want %h %b %b lat=%0d",
               codes[1], ovf[1], bad[1], lat, ec, eo, ed, D);
    end
    ack(1);
  endtask

  initial begin
    in_valid  = '0;
    in_sign   = '0;
    out_ready = '0;
    in_bcd[0] = '0;
    in_bcd[1] = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
